// File: rtl/pulse_pacer_pkg.sv
// Shared types and default parameters for the pulse_pacer block.
// Imported by the interface, the pending counter and the top.
package pulse_pacer_pkg;

    localparam int unsigned CNT_W_DEF      = 4;
    localparam int unsigned GAP_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_pacer_if.sv
// Event/pulse bundle between the event source (master) and pulse_pacer (slave).
interface pulse_pacer_if
    import pulse_pacer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             event_in;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;

    modport master (output event_in, input pulse_out, pending, busy, ovf);
    modport slave  (input event_in, output pulse_out, pending, busy, ovf);

endinterface

// File: rtl/pulse_pacer_cnt.sv
// Saturating up/down counter of accepted-but-unissued events.
// drop flags an increment lost because the counter is already full.
module pulse_pacer_cnt
    import pulse_pacer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             drop
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        drop    = 1'b0;
        // inc together with dec cancels out, so a full counter stays full without dropping.
        if (inc && !dec) begin
            if (count_q == CNT_MAX) begin
                drop = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pulse_pacer.sv
// Paces queued events into single-cycle pulses spaced GAP_CYCLES apart.
// Define PULSE_PACER_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    pulse_pacer_if.slave bus
);

    localparam int unsigned    GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 2);

    state_e           state_q;
    logic [GAP_W-1:0] gap_q;
    logic             pulse_q;
    logic             busy_q;
    logic [CNT_W-1:0] pending;
    logic             drop;
    logic             fire_go;

    // Decision uses the registered count, giving the two-cycle event-to-pulse latency.
    assign fire_go = (pending != '0) &&
                     ((state_q == IDLE) || ((state_q == GAP) && (gap_q == '0)));

    pulse_pacer_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.event_in),
        .dec   (fire_go),
        .count (pending),
        .drop  (drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire_go) begin
                        state_q <= FIRE;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FIRE: begin
                    state_q <= GAP;
                    gap_q   <= GAP_LOAD;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else if (fire_go) begin
                        state_q <= FIRE;
                        pulse_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PULSE_PACER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    // Drop indication has no consumer in this build.
    logic drop_unused;
    assign drop_unused = drop;
    assign bus.ovf     = 1'b0;
`endif

    assign bus.pulse_out = pulse_q;
    assign bus.pending   = pending;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pulse_pacer.sv
// Self-checking bench for pulse_pacer: directed scenarios plus random event/reset
// patterns, compared each cycle against a timing-rule reference model.
module tb_pulse_pacer;

    localparam int CW   = 4;
    localparam int GAP  = 8;
    localparam int MAXP = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pulse_pacer_if #(.CNT_W(CW)) bus ();

    pulse_pacer #(
        .CNT_W      (CW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending count, cycle of the last pulse, and derived outputs.
    int m_pend, m_last, m_pulse, m_busy, m_ovf;
    int max_seen, pulses_seen;
    bit ovf_en;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend  = 0;
        m_last  = -1000;
        m_pulse = 0;
        m_busy  = 0;
        m_ovf   = 0;
    endfunction

    // Compute cycle c from cycle c-1 state and the event sampled in cycle c-1.
    function automatic void model_step(input int c, input bit ev);
        bit fire;
        fire = (m_pend > 0) && (c - m_last >= GAP);
        if (ev && !fire && m_pend == MAXP) begin
            if (ovf_en) m_ovf = 1;
        end else begin
            m_pend = m_pend + int'(ev) - int'(fire);
        end
        if (fire) m_last = c;
        m_pulse = int'(fire);
        m_busy  = int'(c - m_last < GAP);
    endfunction

    task automatic run(input string name, input logic [63:0] ev_map,
                       input logic [63:0] rst_map, input int ncyc);
        bus.event_in = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        model_reset();
        max_seen    = 0;
        pulses_seen = 0;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            rst          = rst_map[c];
            bus.event_in = ev_map[c];
            #1;
            if (rst) model_reset();
            check($sformatf("%s c%0d pulse_out", name, c), int'(bus.pulse_out), m_pulse);
            check($sformatf("%s c%0d pending", name, c), int'(bus.pending), m_pend);
            check($sformatf("%s c%0d busy", name, c), int'(bus.busy), m_busy);
            check($sformatf("%s c%0d ovf", name, c), int'(bus.ovf), m_ovf);
            if (int'(bus.pending) > max_seen) max_seen = int'(bus.pending);
            pulses_seen += int'(bus.pulse_out);
            @(posedge clk);
            if (!rst_map[c]) model_step(c + 1, ev_map[c]);
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] ev;
        logic [63:0] rm;
        int dens;

`ifdef PULSE_PACER_OVF_EN
        ovf_en = 1'b1;
`else
        ovf_en = 1'b0;
`endif
        bus.event_in = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("async reset pulse_out", int'(bus.pulse_out), 0);
        check("async reset pending", int'(bus.pending), 0);
        check("async reset busy", int'(bus.busy), 0);
        check("async reset ovf", int'(bus.ovf), 0);

        ev = '0; rm = '0;
        ev[10] = 1'b1;
        run("single", ev, rm, 30);
        check("single pulse count", pulses_seen, 1);

        ev = '0;
        for (int i = 10; i <= 12; i++) ev[i] = 1'b1;
        run("burst", ev, rm, 40);
        check("burst pulse count", pulses_seen, 3);

        ev = '0;
        ev[10] = 1'b1; ev[14] = 1'b1;
        run("late", ev, rm, 30);
        check("late pulse count", pulses_seen, 2);

        ev = '0;
        for (int i = 10; i <= 39; i++) ev[i] = 1'b1;
        run("sat", ev, rm, 48);
        check("sat max pending", max_seen, MAXP);

        ev = '0; rm = '0;
        ev[10] = 1'b1; ev[11] = 1'b1; ev[20] = 1'b1;
        rm[15] = 1'b1;
        run("rstgap", ev, rm, 30);
        check("rstgap pulse count", pulses_seen, 2);

        for (int r = 0; r < 20; r++) begin
            dens = $urandom_range(90, 10);
            ev = '0; rm = '0;
            for (int i = 0; i < 64; i++) ev[i] = ($urandom_range(99) < dens);
            if ($urandom_range(2) == 0) begin
                int p;
                p = $urandom_range(60, 3);
                rm[p] = 1'b1;
                if ($urandom_range(1) == 1) rm[p + 1] = 1'b1;
            end
            run($sformatf("rnd%0d", r), ev, rm, 64);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
